// File: rtl/sop_fir_pipe.sv
// sop_fir_pipe: parametrised, fully pipelined direct-form FIR engine
// with run-time coefficients, round-half-up scaling and saturation.
module sop_fir_pipe #(
    parameter int WIDTH  = 16,
    parameter int CWIDTH = 16,
    parameter int TAPS   = 8,
    parameter int FRAC   = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic signed [WIDTH-1:0]   x,
    input  logic                      x_valid,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [CWIDTH-1:0]  coef_data,
    input  logic                      clear_ovf,
    output logic signed [WIDTH-1:0]   y,
    output logic                      y_valid,
    output logic                      ovf
);

    localparam int LOG  = $clog2(TAPS);
    localparam int NP   = 1 << LOG;
    localparam int NN   = 2 * NP - 1;
    localparam int PW   = WIDTH + CWIDTH;
    localparam int ACCW = PW + LOG;
    localparam int RW   = ACCW + 1;
    localparam int L    = 3 + LOG;
    localparam int SH   = (FRAC > 0) ? FRAC - 1 : 0;

    localparam logic signed [RW-1:0] HALF =
        (FRAC > 0) ? ({{(RW-1){1'b0}}, 1'b1} << SH) : '0;
    localparam logic signed [RW-1:0] MAXV =
        {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV =
        {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] MAXW = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINW = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0]  d_q    [TAPS];
    logic signed [WIDTH-1:0]  d_d    [TAPS];
    logic signed [CWIDTH-1:0] c_q    [TAPS];
    logic signed [CWIDTH-1:0] c_d    [TAPS];
    logic signed [PW-1:0]     prod   [TAPS];
    logic signed [ACCW-1:0]   node_q [NN];
    logic signed [ACCW-1:0]   node_d [NN];
    logic signed [RW-1:0]     acc_x;
    logic signed [RW-1:0]     rnd_q, rnd_d;
    logic signed [WIDTH-1:0]  sat_val;
    logic                     clip;
    logic [L-1:0]             vld_q, vld_d;
    logic signed [WIDTH-1:0]  y_q, y_d;
    logic                     y_valid_q, y_valid_d;
    logic                     ovf_q, ovf_d;

    // Delay line shifts on accepted samples; coefficient port writes in range.
    always_comb begin
        d_d = d_q;
        c_d = c_q;
        if (x_valid) begin
            d_d[0] = x;
            for (int i = 1; i < TAPS; i++) begin
                d_d[i] = d_q[i-1];
            end
        end
        if (coef_we && (int'(coef_addr) < TAPS)) begin
            c_d[coef_addr] = coef_data;
        end
    end

    // Heap-ordered adder tree: leaves hold products, node n sums 2n+1, 2n+2.
    always_comb begin
        node_d = node_q;
        for (int i = 0; i < TAPS; i++) begin
            prod[i] = PW'(d_q[i]) * PW'(c_q[i]);
            node_d[NP-1+i] = ACCW'(prod[i]);
        end
        for (int i = TAPS; i < NP; i++) begin
            node_d[NP-1+i] = '0;
        end
        for (int n = 0; n < NP - 1; n++) begin
            node_d[n] = node_q[2*n+1] + node_q[2*n+2];
        end
    end

    // Round half up and scale; one spare bit keeps the bias add exact.
    always_comb begin
        acc_x = RW'(node_q[0]);
        rnd_d = acc_x;
        if (FRAC > 0) begin
            rnd_d = (acc_x + HALF) >>> FRAC;
        end
    end

    // Saturate, advance the valid train, hold y between results, track ovf.
    always_comb begin
        sat_val = rnd_q[WIDTH-1:0];
        clip    = 1'b0;
        if (rnd_q > MAXV) begin
            sat_val = MAXW;
            clip    = 1'b1;
        end else if (rnd_q < MINV) begin
            sat_val = MINW;
            clip    = 1'b1;
        end
        vld_d     = {vld_q[L-2:0], x_valid};
        y_valid_d = vld_q[L-1];
        y_d       = vld_q[L-1] ? sat_val : y_q;
        ovf_d     = ovf_q;
        if (clear_ovf) begin
            ovf_d = 1'b0;
        end
        if (vld_q[L-1] && clip) begin
            ovf_d = 1'b1;
        end
    end

    // All state registers; reset flushes data and kills in-flight samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                d_q[i] <= '0;
                c_q[i] <= '0;
            end
            for (int n = 0; n < NN; n++) begin
                node_q[n] <= '0;
            end
            rnd_q     <= '0;
            vld_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            d_q       <= d_d;
            c_q       <= c_d;
            node_q    <= node_d;
            rnd_q     <= rnd_d;
            vld_q     <= vld_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_sop_fir_pipe.sv
// tb_sop_fir_pipe: randomized self-checking bench for sop_fir_pipe,
// compared against a plain-arithmetic FIR model (8-tap and 5-tap DUTs).
module tb_sop_fir_pipe;

    localparam int LAT = 6;

    typedef struct {
        int          due;
        logic [15:0] y;
        bit          sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] x = '0;
    logic        x_valid = 1'b0;
    logic        clear_ovf = 1'b0;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        coef_we5 = 1'b0;
    logic [2:0]  coef_addr5 = '0;
    logic [15:0] coef_data5 = '0;
    logic [15:0] y, y5;
    logic        y_valid, y_valid5, ovf, ovf5;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          mc [2][8];
    int          md [2][8];
    exp_t        q0 [$];
    exp_t        q1 [$];
    bit          ev [2];
    logic [15:0] ey [2];
    bit          eo [2];

    sop_fir_pipe u_dut (
        .clock(clk), .reset(reset), .x(x), .x_valid(x_valid),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .clear_ovf(clear_ovf), .y(y), .y_valid(y_valid), .ovf(ovf)
    );

    sop_fir_pipe #(.TAPS(5)) u_dut5 (
        .clock(clk), .reset(reset), .x(x), .x_valid(x_valid),
        .coef_we(coef_we5), .coef_addr(coef_addr5), .coef_data(coef_data5),
        .clear_ovf(clear_ovf), .y(y5), .y_valid(y_valid5), .ovf(ovf5)
    );

    always #5 clk = ~clk;

    // Reference: full-precision sum of products, round half up, clip.
    function automatic exp_t predict(int m);
        exp_t   e;
        longint acc = 0;
        longint r;
        int     nt = (m == 0) ? 8 : 5;
        for (int i = 0; i < nt; i++)
            acc += longint'(md[m][i]) * longint'(mc[m][i]);
        r = (acc + 64'sd16384) >>> 15;
        e.due = cyc + 1 + LAT;
        e.sat = (r > 32767) || (r < -32768);
        if (r > 32767) e.y = 16'h7fff;
        else if (r < -32768) e.y = 16'h8000;
        else e.y = r[15:0];
        return e;
    endfunction

    // One clock edge: update the model from the driven inputs, then
    // resolve what each DUT must show after the edge.
    task automatic tick();
        bit   rst = reset;
        bit   clr = clear_ovf;
        exp_t e;
        if (rst) begin
            for (int m = 0; m < 2; m++)
                for (int i = 0; i < 8; i++) begin
                    mc[m][i] = 0;
                    md[m][i] = 0;
                end
            q0.delete();
            q1.delete();
        end else begin
            if (coef_we)
                mc[0][coef_addr] = int'($signed(coef_data));
            if (coef_we5 && coef_addr5 < 3'd5)
                mc[1][coef_addr5] = int'($signed(coef_data5));
            if (x_valid) begin
                for (int m = 0; m < 2; m++) begin
                    for (int i = 7; i > 0; i--) md[m][i] = md[m][i-1];
                    md[m][0] = int'($signed(x));
                end
                q0.push_back(predict(0));
                q1.push_back(predict(1));
            end
        end
        @(posedge clk);
        cyc++;
        for (int m = 0; m < 2; m++) begin
            ev[m] = 1'b0;
            if (rst) begin
                ey[m] = '0;
                eo[m] = 1'b0;
            end else begin
                e.due = -1;
                if (clr) eo[m] = 1'b0;
                if (m == 0 && q0.size() > 0 && q0[0].due == cyc)
                    e = q0.pop_front();
                if (m == 1 && q1.size() > 0 && q1[0].due == cyc)
                    e = q1.pop_front();
                if (e.due == cyc) begin
                    ev[m] = 1'b1;
                    ey[m] = e.y;
                    if (e.sat) eo[m] = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        x_valid = 0;
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic load(input int m, input int a, input logic [15:0] v);
        if (m == 0) begin
            coef_we = 1; coef_addr = a[2:0]; coef_data = v;
        end else begin
            coef_we5 = 1; coef_addr5 = a[2:0]; coef_data5 = v;
        end
        tick();
        coef_we = 0;
        coef_we5 = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        x_valid = 1;
        x = 16'h1234;
        repeat (3) begin
            tick();
            checks++;
            if ({y_valid, y, ovf, y_valid5, y5, ovf5} !== 36'h0) begin
                errors++;
                $display("FAIL reset got v=%b y=%h ovf=%b v5=%b y5=%h ovf5=%b req all 0",
                         y_valid, y, ovf, y_valid5, y5, ovf5);
            end
        end
        reset = 0;
        x_valid = 0;
    endtask

    task automatic test_impulse();
        int k = 0;
        int t0 = 0;
        do_reset();
        for (int i = 0; i < 8; i++) load(0, i, 16'(16'h0100 * (i + 1)));
        for (int n = 0; n < 24; n++) begin
            x_valid = (n < 8);
            x = (n == 0) ? 16'h4000 : 16'h0000;
            tick();
            if (n == 0) t0 = cyc;
            checks++;
            if ({y_valid, y, ovf} !== {ev[0], ey[0], eo[0]}) begin
                errors++;
                $display("FAIL impulse cyc=%0d got v=%b y=%h ovf=%b req v=%b y=%h ovf=%b",
                         cyc, y_valid, y, ovf, ev[0], ey[0], eo[0]);
            end
            if (y_valid) begin
                checks++;
                if (y !== 16'(16'h0080 * (k + 1))) begin
                    errors++;
                    $display("FAIL impulse_val k=%0d got %h req %h",
                             k, y, 16'(16'h0080 * (k + 1)));
                end
                if (k == 0) begin
                    checks++;
                    if (cyc - t0 != 6) begin
                        errors++;
                        $display("FAIL latency got %0d req 6", cyc - t0);
                    end
                end
                k++;
            end
        end
        x_valid = 0;
        checks++;
        if (k != 8 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL impulse_count got pulses=%0d ovf=%b req 8 0", k, ovf);
        end
    endtask

    task automatic test_step();
        int k = 0;
        do_reset();
        for (int i = 0; i < 8; i++) load(0, i, 16'h4000);
        for (int n = 0; n < 22; n++) begin
            x_valid = 1;
            x = 16'h1000;
            tick();
            checks++;
            if ({y_valid, y, ovf} !== {ev[0], ey[0], eo[0]}) begin
                errors++;
                $display("FAIL step cyc=%0d got v=%b y=%h ovf=%b req v=%b y=%h ovf=%b",
                         cyc, y_valid, y, ovf, ev[0], ey[0], eo[0]);
            end
            if (y_valid) begin
                checks++;
                if (y !== ((k >= 7) ? 16'h4000 : 16'(16'h0800 * (k + 1)))) begin
                    errors++;
                    $display("FAIL step_val k=%0d got %h", k, y);
                end
                k++;
            end
        end
        x_valid = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 8; i++) load(0, i, 16'h7fff);
        for (int ph = 0; ph < 4; ph++) begin
            for (int n = 0; n < 16; n++) begin
                x_valid = 1;
                clear_ovf = (ph == 3);
                x = (ph == 0 || ph == 3) ? 16'h7fff
                  : (ph == 1) ? 16'h8000 : 16'h0000;
                tick();
                checks++;
                if ({y_valid, y, ovf} !== {ev[0], ey[0], eo[0]}) begin
                    errors++;
                    $display("FAIL sat ph=%0d cyc=%0d got v=%b y=%h ovf=%b req v=%b y=%h ovf=%b",
                             ph, cyc, y_valid, y, ovf, ev[0], ey[0], eo[0]);
                end
            end
            if (ph == 2) begin
                x_valid = 0;
                clear_ovf = 1;
                tick();
                clear_ovf = 0;
            end
            checks++;
            case (ph)
                0: if (y !== 16'h7fff || ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_pos got y=%h ovf=%b req 7fff 1", y, ovf);
                end
                1: if (y !== 16'h8000 || ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_neg got y=%h ovf=%b req 8000 1", y, ovf);
                end
                2: if (ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_clear got %b req 0", ovf);
                end
                default: if (ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_set_wins got %b req 1", ovf);
                end
            endcase
        end
        clear_ovf = 0;
        x_valid = 0;
    endtask

    task automatic test_rounding();
        logic [15:0] rx [3] = '{16'h4000, 16'hc000, 16'h2000};
        logic [15:0] ry [3] = '{16'h0001, 16'h0000, 16'h0000};
        int k = 0;
        do_reset();
        load(0, 0, 16'h0001);
        for (int n = 0; n < 40; n++) begin
            x_valid = (n < 3) ? 1'b1 : 1'($urandom_range(0, 1));
            x = (n < 3) ? rx[n] : 16'($urandom);
            tick();
            checks++;
            if ({y_valid, y, ovf} !== {ev[0], ey[0], eo[0]}) begin
                errors++;
                $display("FAIL round cyc=%0d got v=%b y=%h ovf=%b req v=%b y=%h ovf=%b",
                         cyc, y_valid, y, ovf, ev[0], ey[0], eo[0]);
            end
            if (y_valid && k < 3) begin
                checks++;
                if (y !== ry[k]) begin
                    errors++;
                    $display("FAIL round_val x=%h got %h req %h", rx[k], y, ry[k]);
                end
                k++;
            end
        end
        x_valid = 0;
    endtask

    task automatic test_gapped_coef();
        bit xv [64];
        do_reset();
        for (int i = 0; i < 8; i++) load(0, i, 16'($urandom_range(0, 16'h3fff)));
        for (int i = 0; i < 5; i++) load(1, i, 16'($urandom_range(0, 16'h3fff)));
        for (int n = 0; n < 48; n++) begin
            x_valid = (n % 2 == 0) && (n < 40);
            xv[n] = x_valid;
            x = 16'($urandom);
            coef_we = (n == 16);
            coef_addr = 3'd0;
            coef_data = 16'($urandom);
            coef_we5 = (n == 18 || n == 20 || n == 24);
            coef_addr5 = (n == 18) ? 3'd5 : (n == 20) ? 3'd7 : 3'd0;
            coef_data5 = 16'($urandom);
            tick();
            checks++;
            if ({y_valid, y, ovf} !== {ev[0], ey[0], eo[0]}) begin
                errors++;
                $display("FAIL gapped cyc=%0d got v=%b y=%h ovf=%b req v=%b y=%h ovf=%b",
                         cyc, y_valid, y, ovf, ev[0], ey[0], eo[0]);
            end
            checks++;
            if ({y_valid5, y5, ovf5} !== {ev[1], ey[1], eo[1]}) begin
                errors++;
                $display("FAIL gapped5 cyc=%0d got v=%b y=%h ovf=%b req v=%b y=%h ovf=%b",
                         cyc, y_valid5, y5, ovf5, ev[1], ey[1], eo[1]);
            end
            if (n >= LAT) begin
                checks++;
                if (y_valid !== xv[n-LAT]) begin
                    errors++;
                    $display("FAIL gap_pattern n=%0d got %b req %b",
                             n, y_valid, xv[n-LAT]);
                end
            end
        end
        coef_we = 0;
        coef_we5 = 0;
        x_valid = 0;
    endtask

    task automatic test_reset_midstream();
        int k = 0;
        do_reset();
        for (int i = 0; i < 8; i++) load(0, i, 16'h7fff);
        for (int n = 0; n < 8; n++) begin
            x_valid = (n < 6);
            x = 16'h7fff;
            tick();
        end
        checks++;
        if (ovf !== 1'b1 || ovf !== eo[0]) begin
            errors++;
            $display("FAIL pre_reset_ovf got %b req 1", ovf);
        end
        reset = 1;
        x_valid = 0;
        tick();
        reset = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if ({y_valid, y, ovf} !== 18'h0) begin
                errors++;
                $display("FAIL mid_reset cyc=%0d got v=%b y=%h ovf=%b req 0 0 0",
                         cyc, y_valid, y, ovf);
            end
        end
        load(0, 0, 16'h0100);
        for (int n = 0; n < 18; n++) begin
            x_valid = (n < 8);
            x = (n == 0) ? 16'h4000 : 16'h0000;
            tick();
            checks++;
            if ({y_valid, y, ovf} !== {ev[0], ey[0], eo[0]}) begin
                errors++;
                $display("FAIL post_reset cyc=%0d got v=%b y=%h ovf=%b req v=%b y=%h ovf=%b",
                         cyc, y_valid, y, ovf, ev[0], ey[0], eo[0]);
            end
            if (y_valid) begin
                checks++;
                if (y !== ((k == 0) ? 16'h0080 : 16'h0000)) begin
                    errors++;
                    $display("FAIL post_reset_val k=%0d got %h", k, y);
                end
                k++;
            end
        end
        x_valid = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] r8;
        do_reset();
        for (int i = 0; i < 8; i++) load(0, i, 16'($urandom));
        for (int i = 0; i < 5; i++) load(1, i, 16'($urandom));
        for (int n = 0; n < 300; n++) begin
            r8 = 8'($urandom);
            x_valid = ($urandom_range(0, 4) != 0);
            x = $urandom_range(0, 1) ? 16'($urandom) : {{8{r8[7]}}, r8};
            coef_we = ($urandom_range(0, 9) == 0);
            coef_addr = 3'($urandom);
            coef_data = 16'($urandom);
            coef_we5 = ($urandom_range(0, 9) == 0);
            coef_addr5 = 3'($urandom);
            coef_data5 = 16'($urandom);
            clear_ovf = ($urandom_range(0, 7) == 0);
            tick();
            checks++;
            if ({y_valid, y, ovf} !== {ev[0], ey[0], eo[0]}) begin
                errors++;
                $display("FAIL b2b cyc=%0d got v=%b y=%h ovf=%b req v=%b y=%h ovf=%b",
                         cyc, y_valid, y, ovf, ev[0], ey[0], eo[0]);
            end
            checks++;
            if ({y_valid5, y5, ovf5} !== {ev[1], ey[1], eo[1]}) begin
                errors++;
                $display("FAIL b2b5 cyc=%0d got v=%b y=%h ovf=%b req v=%b y=%h ovf=%b",
                         cyc, y_valid5, y5, ovf5, ev[1], ey[1], eo[1]);
            end
        end
        x_valid = 0;
        coef_we = 0;
        coef_we5 = 0;
        clear_ovf = 0;
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_step();
        test_saturation();
        test_rounding();
        test_gapped_coef();
        test_reset_midstream();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
